// File: rtl/jtvigil_arb_pkg.sv
// Shared types and helpers for the three-requester SDRAM bank-0 arbiter.
package jtvigil_arb_pkg;

  localparam int unsigned BA_AW    = 22;          // SDRAM word address width
  localparam int unsigned MAIN_AW  = 18;          // main CPU byte address width
  localparam int unsigned SUB_AW   = 16;          // sound / PCM byte address width
  localparam int unsigned MAIN_WAW = MAIN_AW - 1; // widest latched word address
  localparam int unsigned DW       = 16;          // SDRAM data width

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    WAIT_RDY = 2'd2
  } arb_state_e;

  localparam logic [1:0] REQ_MAIN = 2'd0;
  localparam logic [1:0] REQ_SND  = 2'd1;
  localparam logic [1:0] REQ_PCM  = 2'd2;

  // Three-way round-robin: first pending requester after the last one granted.
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] pend);
    logic [1:0] pick;
    pick = REQ_MAIN;
    case (last)
      REQ_MAIN: begin
        if (pend[REQ_SND])       pick = REQ_SND;
        else if (pend[REQ_PCM])  pick = REQ_PCM;
        else                     pick = REQ_MAIN;
      end
      REQ_SND: begin
        if (pend[REQ_PCM])       pick = REQ_PCM;
        else if (pend[REQ_MAIN]) pick = REQ_MAIN;
        else                     pick = REQ_SND;
      end
      default: begin
        if (pend[REQ_MAIN])      pick = REQ_MAIN;
        else if (pend[REQ_SND])  pick = REQ_SND;
        else                     pick = REQ_PCM;
      end
    endcase
    return pick;
  endfunction

  // Main always wins; sound and PCM alternate; 'last' tracks only sound/PCM grants.
  function automatic logic [1:0] prio_pick(input logic [1:0] last, input logic [2:0] pend);
    logic [1:0] pick;
    pick = REQ_MAIN;
    if (pend[REQ_MAIN])                      pick = REQ_MAIN;
    else if (pend[REQ_SND] && pend[REQ_PCM]) pick = (last == REQ_SND) ? REQ_PCM : REQ_SND;
    else if (pend[REQ_SND])                  pick = REQ_SND;
    else                                     pick = REQ_PCM;
    return pick;
  endfunction

endpackage

// File: rtl/jtvigil_arb_cache.sv
// One-word read cache for a single requester; hit and byte select are combinational.
module jtvigil_arb_cache
  import jtvigil_arb_pkg::*;
#(
  parameter int unsigned AW = 16  // requester byte address width
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          we,
  input  logic [AW-2:0] wr_waddr,
  input  logic [DW-1:0] wr_data,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  output logic          ok_c,
  output logic [7:0]    data_c
);

  logic          valid_q, valid_d;
  logic [AW-2:0] waddr_q, waddr_d;
  logic [DW-1:0] data_q,  data_d;

  // Fill on write; a flush wins and invalidates the entry.
  always_comb begin
    valid_d = valid_q;
    waddr_d = waddr_q;
    data_d  = data_q;
    if (we) begin
      valid_d = 1'b1;
      waddr_d = wr_waddr;
      data_d  = wr_data;
    end
    if (flush) valid_d = 1'b0;
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      waddr_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      waddr_q <= waddr_d;
      data_q  <= data_d;
    end
  end

  assign ok_c   = cs & valid_q & (waddr_q == addr[AW-1:1]);
  assign data_c = addr[0] ? data_q[15:8] : data_q[7:0];

endmodule

// File: rtl/jtvigil_ba0_arb.sv
// SDRAM bank-0 arbiter for main CPU, sound CPU and PCM ROM reads.
// Optional macro JTVIGIL_MAIN_PRIO_EN: main wins outright, sound/PCM round-robin.
module jtvigil_ba0_arb
  import jtvigil_arb_pkg::*;
#(
  parameter logic [21:0] MAIN_OFFSET = 22'h00000,
  parameter logic [21:0] SND_OFFSET  = 22'h20000,
  parameter logic [21:0] PCM_OFFSET  = 22'h28000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        downloading,
  input  logic        main_cs,
  input  logic        snd_cs,
  input  logic        pcm_cs,
  input  logic [17:0] main_addr,
  input  logic [15:0] snd_addr,
  input  logic [15:0] pcm_addr,
  output logic [7:0]  main_data,
  output logic [7:0]  snd_data,
  output logic [7:0]  pcm_data,
  output logic        main_ok,
  output logic        snd_ok,
  output logic        pcm_ok,
  output logic [21:0] ba_addr,
  output logic        ba_rd,
  input  logic        ba_ack,
  input  logic        ba_rdy,
  input  logic [15:0] data_read
);

  arb_state_e           state_q, state_d;
  logic [1:0]           gnt_q, gnt_d;
  logic [1:0]           last_q, last_d;
  logic [MAIN_WAW-1:0]  lat_q, lat_d;
  logic [BA_AW-1:0]     ba_addr_q, ba_addr_d;
  logic                 ba_rd_q, ba_rd_d;
  logic                 drop_q, drop_d;
  logic [2:0]           pend;
  logic [1:0]           pick;
  logic [MAIN_WAW-1:0]  pick_waddr;
  logic [BA_AW-1:0]     pick_ba;
  logic                 fill_c;
  logic                 wr_en_c;

  // Pending requesters, arbitration winner and its SDRAM word address.
  always_comb begin
    pend = {pcm_cs & ~pcm_ok, snd_cs & ~snd_ok, main_cs & ~main_ok};
`ifdef JTVIGIL_MAIN_PRIO_EN
    pick = prio_pick(last_q, pend);
`else
    pick = rr_pick(last_q, pend);
`endif
    pick_waddr = main_addr[MAIN_AW-1:1];
    pick_ba    = BA_AW'(main_addr[MAIN_AW-1:1]) + MAIN_OFFSET;
    case (pick)
      REQ_SND: begin
        pick_waddr = MAIN_WAW'(snd_addr[SUB_AW-1:1]);
        pick_ba    = BA_AW'(snd_addr[SUB_AW-1:1]) + SND_OFFSET;
      end
      REQ_PCM: begin
        pick_waddr = MAIN_WAW'(pcm_addr[SUB_AW-1:1]);
        pick_ba    = BA_AW'(pcm_addr[SUB_AW-1:1]) + PCM_OFFSET;
      end
      default: ;
    endcase
  end

  // Transfer FSM: grant, hold the request until ack, then wait for data.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    lat_d     = lat_q;
    ba_addr_d = ba_addr_q;
    ba_rd_d   = ba_rd_q;
    drop_d    = drop_q | downloading;
    fill_c    = 1'b0;
    case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if ((|pend) && !downloading) begin
          gnt_d     = pick;
`ifdef JTVIGIL_MAIN_PRIO_EN
          if (pick != REQ_MAIN) last_d = pick;
`else
          last_d    = pick;
`endif
          lat_d     = pick_waddr;
          ba_addr_d = pick_ba;
          ba_rd_d   = 1'b1;
          state_d   = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ba_ack) begin
          ba_rd_d = 1'b0;
          if (ba_rdy) begin
            fill_c  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT_RDY;
          end
        end
      end
      WAIT_RDY: begin
        if (ba_rdy) begin
          fill_c  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        ba_rd_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // A fill seen during or after a download window is thrown away.
  assign wr_en_c = fill_c & ~drop_q & ~downloading;

  // FSM and request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= REQ_MAIN;
      last_q    <= REQ_PCM;
      lat_q     <= '0;
      ba_addr_q <= '0;
      ba_rd_q   <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      lat_q     <= lat_d;
      ba_addr_q <= ba_addr_d;
      ba_rd_q   <= ba_rd_d;
      drop_q    <= drop_d;
    end
  end

  assign ba_addr = ba_addr_q;
  assign ba_rd   = ba_rd_q;

  jtvigil_arb_cache #(.AW(MAIN_AW)) u_main_cache (
    .clk(clk), .rst(rst), .flush(downloading),
    .we(wr_en_c & (gnt_q == REQ_MAIN)), .wr_waddr(lat_q), .wr_data(data_read),
    .cs(main_cs), .addr(main_addr), .ok_c(main_ok), .data_c(main_data)
  );

  jtvigil_arb_cache #(.AW(SUB_AW)) u_snd_cache (
    .clk(clk), .rst(rst), .flush(downloading),
    .we(wr_en_c & (gnt_q == REQ_SND)), .wr_waddr(lat_q[SUB_AW-2:0]), .wr_data(data_read),
    .cs(snd_cs), .addr(snd_addr), .ok_c(snd_ok), .data_c(snd_data)
  );

  jtvigil_arb_cache #(.AW(SUB_AW)) u_pcm_cache (
    .clk(clk), .rst(rst), .flush(downloading),
    .we(wr_en_c & (gnt_q == REQ_PCM)), .wr_waddr(lat_q[SUB_AW-2:0]), .wr_data(data_read),
    .cs(pcm_cs), .addr(pcm_addr), .ok_c(pcm_ok), .data_c(pcm_data)
  );

endmodule

// File: tb/tb_jtvigil_ba0_arb.sv
// Bench for jtvigil_ba0_arb: transaction-level reference model plus SDRAM responder.
module tb_jtvigil_ba0_arb;

  localparam logic [21:0] MAIN_OFF = 22'h00000;
  localparam logic [21:0] SND_OFF  = 22'h20000;
  localparam logic [21:0] PCM_OFF  = 22'h28000;

  logic        clk = 1'b0;
  logic        rst, downloading;
  logic        main_cs, snd_cs, pcm_cs;
  logic [17:0] main_addr;
  logic [15:0] snd_addr, pcm_addr;
  logic [7:0]  main_data, snd_data, pcm_data;
  logic        main_ok, snd_ok, pcm_ok;
  logic [21:0] ba_addr;
  logic        ba_rd, ba_ack, ba_rdy;
  logic [15:0] data_read;

  jtvigil_ba0_arb dut (
    .clk(clk), .rst(rst), .downloading(downloading),
    .main_cs(main_cs), .snd_cs(snd_cs), .pcm_cs(pcm_cs),
    .main_addr(main_addr), .snd_addr(snd_addr), .pcm_addr(pcm_addr),
    .main_data(main_data), .snd_data(snd_data), .pcm_data(pcm_data),
    .main_ok(main_ok), .snd_ok(snd_ok), .pcm_ok(pcm_ok),
    .ba_addr(ba_addr), .ba_rd(ba_rd), .ba_ack(ba_ack), .ba_rdy(ba_rdy),
    .data_read(data_read)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: cache contents plus the single in-flight transaction.
  bit          mv[3];
  int unsigned mw[3];
  logic [15:0] md[3];
  bit          tr_act, tr_acc, tr_doom;
  int          tr_who;
  int unsigned tr_word;
  int          last_who, last_sp;
  int          ack_cnt, rdy_cnt;
  int          fix_ack = -1, fix_rdy = -1;
  bit          use_fix = 0;
  logic [15:0] fix_data = 16'h0;

  typedef struct {
    logic [2:0]  mask;
    logic [17:0] ma;
    logic [15:0] sa;
    logic [15:0] pa;
    logic [21:0] exp_ba;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem(input logic [21:0] w);
    return {w[7:0] ^ 8'h5C, w[15:8] ^ {2'b00, w[21:16]} ^ 8'h93};
  endfunction

  function automatic bit cs_of(input int i);
    case (i)
      0: return main_cs;
      1: return snd_cs;
      default: return pcm_cs;
    endcase
  endfunction

  function automatic int unsigned wa_of(input int i);
    case (i)
      0: return 32'(main_addr) >> 1;
      1: return 32'(snd_addr) >> 1;
      default: return 32'(pcm_addr) >> 1;
    endcase
  endfunction

  function automatic bit lo_of(input int i);
    case (i)
      0: return main_addr[0];
      1: return snd_addr[0];
      default: return pcm_addr[0];
    endcase
  endfunction

  function automatic logic [21:0] off_of(input int i);
    case (i)
      0: return MAIN_OFF;
      1: return SND_OFF;
      default: return PCM_OFF;
    endcase
  endfunction

  function automatic logic ok_of(input int i);
    case (i)
      0: return main_ok;
      1: return snd_ok;
      default: return pcm_ok;
    endcase
  endfunction

  function automatic logic [7:0] dat_of(input int i);
    case (i)
      0: return main_data;
      1: return snd_data;
      default: return pcm_data;
    endcase
  endfunction

  function automatic logic [21:0] tr_ba();
    return 22'(tr_word) + off_of(tr_who);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) mv[i] = 0;
    tr_act = 0; tr_acc = 0; tr_doom = 0;
    last_who = 2; last_sp = 2;
  endtask

  // Compare every DUT output with what the model predicts for this cycle.
  task automatic check_model();
    for (int i = 0; i < 3; i++) begin
      bit e;
      e = cs_of(i) && mv[i] && (mw[i] == wa_of(i));
      chk($sformatf("ok%0d", i), 32'(ok_of(i)), 32'(e));
      if (e) chk($sformatf("data%0d", i), 32'(dat_of(i)), 32'(lo_of(i) ? md[i][15:8] : md[i][7:0]));
    end
    chk("ba_rd", 32'(ba_rd), 32'(tr_act && !tr_acc));
    if (tr_act && !tr_acc) chk("ba_addr", 32'(ba_addr), 32'(tr_ba()));
  endtask

  // Advance the model across one clock edge using the inputs held over that edge.
  task automatic model_step();
    bit pend[3];
    bit done;
    int who;
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 3; i++) pend[i] = cs_of(i) && !(mv[i] && mw[i] == wa_of(i));
    if (tr_act) begin
      done = 0;
      if (downloading) tr_doom = 1;
      if (!tr_acc) begin
        if (ba_ack) begin
          tr_acc = 1;
          if (ba_rdy) done = 1; else rdy_cnt--;
        end else ack_cnt--;
      end else begin
        if (ba_rdy) done = 1; else rdy_cnt--;
      end
      if (done) begin
        if (!tr_doom) begin
          mv[tr_who] = 1; mw[tr_who] = tr_word; md[tr_who] = data_read;
        end
        tr_act = 0;
      end
    end else if (!downloading && (pend[0] || pend[1] || pend[2])) begin
      who = -1;
`ifdef JTVIGIL_MAIN_PRIO_EN
      if (pend[0]) who = 0;
      else begin
        if (pend[1] && pend[2]) who = (last_sp == 1) ? 2 : 1;
        else who = pend[1] ? 1 : 2;
        last_sp = who;
      end
`else
      for (int k = 1; k <= 3; k++) begin
        if (who < 0 && pend[(last_who + k) % 3]) who = (last_who + k) % 3;
      end
      last_who = who;
`endif
      tr_act = 1; tr_acc = 0; tr_doom = 0;
      tr_who = who; tr_word = wa_of(who);
      ack_cnt = (fix_ack >= 0) ? fix_ack : int'($urandom_range(0, 3));
      rdy_cnt = (fix_rdy >= 0) ? fix_rdy : int'($urandom_range(0, 3));
    end
    if (downloading) for (int i = 0; i < 3; i++) mv[i] = 0;
  endtask

  // One clock: check at negedge, drive the SDRAM side, step the model at posedge.
  task automatic cycle();
    @(negedge clk);
    check_model();
    ba_ack    = tr_act && !tr_acc && (ack_cnt == 0);
    ba_rdy    = tr_act && (tr_acc || ack_cnt == 0) && (rdy_cnt == 0);
    data_read = use_fix ? fix_data : mem(tr_ba());
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1; cycle(); cycle(); rst = 0;
  endtask

  task automatic wait_rd(input string name);
    bit got;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      if (ba_rd) begin got = 1; break; end
      cycle();
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: ba_rd never rose, got 0 expected 1", name);
    end
  endtask

  task automatic wait_low(input string name);
    bit got;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      if (!ba_rd) begin got = 1; break; end
      cycle();
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: ba_rd stuck, got 1 expected 0", name);
    end
  endtask

  task automatic wait_ok(input string name, input int i);
    bit got;
    got = 0;
    for (int k = 0; k < 60; k++) begin
      if (ok_of(i)) begin got = 1; break; end
      cycle();
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: ok%0d never rose, got 0 expected 1", name, i);
    end
  endtask

  initial begin
    int n;
    logic [15:0] w;
    int dl_left;

    vecs[0] = '{3'b001, 18'h3FFFF, 16'h0000, 16'h0000, 22'h01FFFF};
    vecs[1] = '{3'b010, 18'h00000, 16'h1234, 16'h0000, 22'h02091A};
    vecs[2] = '{3'b110, 18'h00000, 16'h0001, 16'h0040, 22'h020000};
    vecs[3] = '{3'b100, 18'h00000, 16'h0000, 16'hFFFF, 22'h02FFFF};
    vecs[4] = '{3'b101, 18'h00010, 16'h0000, 16'h0002, 22'h000008};

    rst = 1; downloading = 0; ba_ack = 0; ba_rdy = 0; data_read = 16'h0;
    main_cs = 1; snd_cs = 1; pcm_cs = 1;
    main_addr = 18'h0; snd_addr = 16'h0; pcm_addr = 16'h0;
    @(posedge clk); @(posedge clk);
    model_reset();
    #1;
    chk("rst_ba_rd", 32'(ba_rd), 32'h0);
    chk("rst_ba_addr", 32'(ba_addr), 32'h0);
    chk("rst_main_ok", 32'(main_ok), 32'h0);
    chk("rst_snd_ok", 32'(snd_ok), 32'h0);
    chk("rst_pcm_ok", 32'(pcm_ok), 32'h0);
    rst = 0;
    cycle();
    main_cs = 0; snd_cs = 0; pcm_cs = 0;

    // Single miss with fixed ack/rdy latency.
    do_reset();
    fix_ack = 1; fix_rdy = 2; use_fix = 1; fix_data = 16'hA55A;
    main_cs = 1; main_addr = 18'h00003;
    wait_rd("t032_rd");
    chk("t032_ba_addr", 32'(ba_addr), 32'h000001);
    n = 0;
    while (!main_ok && n < 20) begin cycle(); n++; end
    chk("t032_latency", 32'(n), 32'd4);
    chk("t032_main_data", 32'(main_data), 32'hA5);
    use_fix = 0; fix_ack = -1; fix_rdy = -1;

    // Same word, other byte: hit without a new request.
    main_addr = 18'h00010;
    wait_rd("t035_rd");
    chk("t035_ba_addr", 32'(ba_addr), 32'h000008);
    wait_ok("t035_fill", 0);
    main_addr = 18'h00011;
    #1;
    w = mem(22'h000008);
    chk("t035_hit", 32'(main_ok), 32'h1);
    chk("t035_hi_byte", 32'(main_data), 32'(w[15:8]));
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t035_no_rd", 32'(ba_rd), 32'h0);
    end
    main_cs = 0;

    // Table: first grant address after reset for various requester mixes.
    foreach (vecs[v]) begin
      do_reset();
      main_cs = vecs[v].mask[0]; snd_cs = vecs[v].mask[1]; pcm_cs = vecs[v].mask[2];
      main_addr = vecs[v].ma; snd_addr = vecs[v].sa; pcm_addr = vecs[v].pa;
      wait_rd($sformatf("vec%0d_rd", v));
      chk($sformatf("vec%0d_ba_addr", v), 32'(ba_addr), 32'(vecs[v].exp_ba));
      for (int k = 0; k < 60; k++) begin
        if ((!main_cs || main_ok) && (!snd_cs || snd_ok) && (!pcm_cs || pcm_ok)) break;
        cycle();
      end
      main_cs = 0; snd_cs = 0; pcm_cs = 0;
    end

    // Three simultaneous misses served in order.
    do_reset();
    main_cs = 1; snd_cs = 1; pcm_cs = 1;
    main_addr = 18'h00100; snd_addr = 16'h0200; pcm_addr = 16'h0400;
    wait_rd("t033_rd0");
    chk("t033_main", 32'(ba_addr), 32'h000080);
    wait_low("t033_low0");
    wait_rd("t033_rd1");
    chk("t033_snd", 32'(ba_addr), 32'h020100);
    wait_low("t033_low1");
    wait_rd("t033_rd2");
    chk("t033_pcm", 32'(ba_addr), 32'h028200);
    wait_ok("t033_done", 2);
    main_cs = 0; snd_cs = 0; pcm_cs = 0;

`ifdef JTVIGIL_MAIN_PRIO_EN
    // Main keeps missing: sound and PCM must wait.
    do_reset();
    fix_ack = 0; fix_rdy = 0;
    main_cs = 1; snd_cs = 1; pcm_cs = 1;
    main_addr = 18'h00100; snd_addr = 16'h0200; pcm_addr = 16'h0400;
    for (int j = 0; j < 4; j++) begin
      wait_rd("t034_rd");
      chk($sformatf("t034_main%0d", j), 32'(ba_addr), 32'h80 + 32'(j));
      main_addr = main_addr + 18'd2;
      wait_low("t034_low");
    end
    main_cs = 0;
    wait_rd("t034_snd_rd");
    chk("t034_snd", 32'(ba_addr), 32'h020100);
    wait_low("t034_low_s");
    wait_rd("t034_pcm_rd");
    chk("t034_pcm", 32'(ba_addr), 32'h028200);
    wait_ok("t034_done", 2);
    snd_cs = 0; pcm_cs = 0;
    fix_ack = -1; fix_rdy = -1;
`endif

    // Address change while waiting for data.
    do_reset();
    fix_ack = 0; fix_rdy = 3;
    main_cs = 1; main_addr = 18'h02000;
    wait_rd("t036_rd");
    chk("t036_ba_addr", 32'(ba_addr), 32'h001000);
    cycle();
    main_addr = 18'h03000;
    wait_rd("t036_rd2");
    chk("t036_new_addr", 32'(ba_addr), 32'h001800);
    chk("t036_ok_low", 32'(main_ok), 32'h0);
    wait_ok("t036_done", 0);
    main_cs = 0;
    fix_ack = -1; fix_rdy = -1;

    // Download mid-transfer discards the fill.
    do_reset();
    snd_cs = 1; snd_addr = 16'h0040;
    wait_ok("t037_snd_fill", 1);
    fix_ack = 0; fix_rdy = 4;
    main_cs = 1; main_addr = 18'h00500;
    wait_rd("t037_rd");
    cycle();
    downloading = 1;
    cycle();
    chk("t037_snd_flushed", 32'(snd_ok), 32'h0);
    chk("t037_main_low", 32'(main_ok), 32'h0);
    snd_cs = 0;
    cycle();
    downloading = 0;
    wait_rd("t037_rerd");
    chk("t037_rereq_addr", 32'(ba_addr), 32'h000280);
    chk("t037_no_fill", 32'(main_ok), 32'h0);
    wait_ok("t037_done", 0);
    fix_ack = 5; fix_rdy = 0;
    main_addr = 18'h00600;
    wait_rd("t037_rst_rd");
    rst = 1;
    cycle();
    chk("t037_rst_ba_rd", 32'(ba_rd), 32'h0);
    chk("t037_rst_ba_addr", 32'(ba_addr), 32'h0);
    chk("t037_rst_ok", 32'(main_ok), 32'h0);
    rst = 0;
    fix_ack = -1; fix_rdy = -1;
    main_cs = 0;

    // Random traffic against the model.
    dl_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) main_cs = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 3) == 0) snd_cs  = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 3) == 0) pcm_cs  = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 4) == 0)
        main_addr = 18'($urandom_range(0, 15)) | ($urandom_range(0, 1) != 0 ? 18'h3FFF0 : 18'h0);
      if ($urandom_range(0, 4) == 0)
        snd_addr = 16'($urandom_range(0, 15)) | ($urandom_range(0, 1) != 0 ? 16'hFFF0 : 16'h0);
      if ($urandom_range(0, 4) == 0)
        pcm_addr = 16'($urandom_range(0, 15)) | ($urandom_range(0, 1) != 0 ? 16'h8000 : 16'h0);
      if (dl_left > 0) dl_left--;
      else if ($urandom_range(0, 79) == 0) dl_left = int'($urandom_range(1, 4));
      downloading = (dl_left > 0);
      rst = ($urandom_range(0, 599) == 0);
      cycle();
    end
    rst = 0; downloading = 0;
    main_cs = 0; snd_cs = 0; pcm_cs = 0;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jtvigil_ba0_arb.md
JTVIGIL_BA0_ARB -- requirements
Module: jtvigil_ba0_arb

Interface
REQ-001 Parameter MAIN_OFFSET, default 22'h00000, SDRAM word offset added to main CPU word address.
REQ-002 Parameter SND_OFFSET, default 22'h20000, SDRAM word offset for sound CPU ROM.
REQ-003 Parameter PCM_OFFSET, default 22'h28000, SDRAM word offset for PCM ROM.
REQ-004 clk  input  1  system clock; single clock domain.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 downloading  input  1  ROM load in progress; suspends grants, flushes caches.
REQ-007 main_cs, snd_cs, pcm_cs  input  1 each  requester read strobes.
REQ-008 main_addr  input  18 (byte); snd_addr, pcm_addr  input  16 (byte).
REQ-009 main_data, snd_data, pcm_data  output  8 each  read bytes.
REQ-010 main_ok, snd_ok, pcm_ok  output  1 each  data valid for current address.
REQ-011 ba_addr  output  22  SDRAM word address; ba_rd  output  1  read request.
REQ-012 ba_ack  input  1  request accepted; ba_rdy  input  1  data_read valid.
REQ-013 data_read  input  16  SDRAM word.

Function
REQ-014 Each requester SHALL own a one-word cache: valid bit, word address (byte addr >> 1), 16-bit data.
REQ-015 x_ok SHALL be combinational: x_cs & valid & (cached word addr == x_addr >> 1).
REQ-016 x_data SHALL be cached data[15:8] when x_addr[0]=1, else data[7:0].
REQ-017 A requester is pending when x_cs=1 and x_ok=0.
REQ-018 FSM states IDLE, WAIT_ACK, WAIT_RDY; only one transfer outstanding.
REQ-019 IDLE: if any pending and downloading=0, grant by round-robin order main->snd->pcm starting after last granted; next cycle enter WAIT_ACK.
REQ-020 WAIT_ACK: ba_rd=1, ba_addr = (x_addr>>1) + X_OFFSET latched at grant, held stable; on ba_ack go WAIT_RDY with ba_rd=0.
REQ-021 WAIT_RDY: on ba_rdy write data_read and latched word address into granted cache, set valid, return IDLE; x_ok rises the following cycle.
REQ-022 ba_ack and ba_rdy in same cycle SHALL capture data and return IDLE directly.
REQ-023 Requester address change or cs drop during a transfer: transfer completes and fills cache with the latched address; new address becomes a fresh miss.
REQ-024 Three simultaneous misses SHALL be served in round-robin order, each within 3 grants.
REQ-025 downloading=1: all valid bits cleared each cycle, no new grants; an outstanding transfer completes but its fill is discarded.
REQ-026 Word-address sum SHALL wrap modulo 2^22.

Reset
REQ-027 On rst: FSM IDLE, ba_rd=0, ba_addr=0, all valid=0, all x_ok=0, round-robin pointer so main is first; reset mid-transfer abandons it without waiting for ba_rdy.

Configuration
REQ-028 Macro JTVIGIL_MAIN_PRIO_EN defined: main pending always wins; snd/pcm round-robin between themselves.
REQ-029 Macro undefined: pure three-way round-robin of REQ-019.

Structure
REQ-030 Package jtvigil_arb_pkg SHALL hold the FSM state enum and requester index constants (REQ_MAIN=0, REQ_SND=1, REQ_PCM=2).
REQ-031 Sub-module jtvigil_arb_cache SHALL implement one cache entry (REQ-014..016), instantiated three times.

Verification
REQ-032 main_cs=1, main_addr=18'h00003, ack 2 cycles later, rdy 4 cycles later with 16'hA55A -> ba_addr=22'h00001, main_data=8'hA5, main_ok high the cycle after rdy.
REQ-033 All three cs high with misses (macro undefined) -> grants main, snd, pcm in order; snd ba_addr=SND_OFFSET+(snd_addr>>1).
REQ-034 Same as 033 with JTVIGIL_MAIN_PRIO_EN and main moving to new miss each fill -> snd/pcm wait until main stops missing.
REQ-035 main_addr 18'h10 then 18'h11 -> second access hits, no ba_rd, main_data = high byte.
REQ-036 Change main_addr during WAIT_RDY -> fill completes, main_ok stays 0, new ba_rd for new address.
REQ-037 Assert downloading mid-transfer then release -> no fill, all ok low, re-request after release; rst in WAIT_ACK -> ba_rd=0 next cycle.
